// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the parameterised synchronous FIFO.
// Holds the count-width function and the threshold defaults used by the top level.
package fifo_pkg;

   localparam int DEF_WIDTH    = 8;
   localparam int DEF_DEPTH    = 8;
   localparam int DEF_AE_LEVEL = 2;
   localparam int AF_MARGIN    = 2;
   localparam int MAX_DEPTH    = 1024;
   localparam int MAX_WIDTH    = 64;

   // Occupancy needs one bit more than the pointer so that DEPTH itself is representable.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int def_af_level(input int depth);
      return depth - AF_MARGIN;
   endfunction

   function automatic bit is_pow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Simple dual-port storage: one write port, one registered read port.
// Only the read data register is reset; the array itself is never cleared.
module fifo_mem_dp
   import fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Same-address read and write on one edge returns the old word (full FIFO, read+write).
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO: pointer, occupancy and flag control around fifo_mem_dp.
// All flags are registered from the next-state count, so no input reaches an output combinationally.
module param_sync_fifo
   import fifo_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AF_LEVEL = def_af_level(DEPTH),
   parameter int AE_LEVEL = DEF_AE_LEVEL
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          write_e,
   input  logic                          read_e,
   input  logic [WIDTH-1:0]              data_in,
   output logic [WIDTH-1:0]              data_out,
   output logic                          rd_valid,
   output logic                          full,
   output logic                          empty,
   output logic                          almost_full,
   output logic                          almost_empty,
   output logic [count_width(DEPTH)-1:0] count,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = count_width(DEPTH);

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

   generate
      if (!is_pow2(DEPTH) || (DEPTH < 2) || (DEPTH > MAX_DEPTH)) begin : g_bad_depth
         $error("param_sync_fifo: DEPTH must be a power of two in 2..1024");
      end
      if ((WIDTH < 1) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
         $error("param_sync_fifo: WIDTH must be in 1..64");
      end
      if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
         $error("param_sync_fifo: AE_LEVEL must be below AF_LEVEL");
      end
      if ((AE_LEVEL < 0) || (AF_LEVEL > DEPTH)) begin : g_bad_range
         $error("param_sync_fifo: thresholds must lie within 0..DEPTH");
      end
   endgenerate

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          wr_acc;
   logic          rd_acc;
   logic [CW-1:0] count_nxt;

   // A full FIFO still takes a write when a read frees the slot on the same edge.
   always_comb begin
      wr_acc    = write_e & (~full | read_e);
      rd_acc    = read_e & ~empty;
      count_nxt = count;
      if (wr_acc && !rd_acc) begin
         count_nxt = count + CW'(1);
      end else if (rd_acc && !wr_acc) begin
         count_nxt = count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         rd_valid     <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count        <= count_nxt;
         full         <= (count_nxt == FULL_CNT);
         empty        <= (count_nxt == '0);
         almost_full  <= (count_nxt >= AF_CNT);
         almost_empty <= (count_nxt <= AE_CNT);
         rd_valid     <= rd_acc;
         overflow     <= write_e & ~wr_acc;
         underflow    <= read_e & empty;
      end
   end

   // Reset blocks the array write so that stored contents survive but are never disturbed by it.
   fifo_mem_dp #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_acc & ~reset),
      .wr_addr (wr_ptr),
      .wr_data (data_in),
      .rd_en   (rd_acc & ~reset),
      .rd_addr (rd_ptr),
      .rd_data (data_out)
   );

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo at WIDTH=8, DEPTH=8 with default thresholds.
// Hand-computed expectations, plus a queue scoreboard for the interleaved wrap sequence.
module tb_param_sync_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic       write_e;
   logic       read_e;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       rd_valid;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [3:0] count;
   logic       overflow;
   logic       underflow;

   int         n_total = 0;
   int         n_bad   = 0;
   logic [7:0] sb [$];
   int         m_cnt   = 0;

   always #5 clk = ~clk;

   param_sync_fifo dut (
      .clk          (clk),
      .reset        (reset),
      .write_e      (write_e),
      .read_e       (read_e),
      .data_in      (data_in),
      .data_out     (data_out),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // One clock with the given request; outputs are sampled 1 time unit after the edge.
   task automatic cyc(input logic w, input logic r, input logic [7:0] d);
      write_e = w;
      read_e  = r;
      data_in = d;
      @(posedge clk);
      #1;
      write_e = 1'b0;
      read_e  = 1'b0;
   endtask

   task automatic mcyc(input logic w, input logic r, input logic [7:0] d);
      logic       rd_ok;
      logic       wr_ok;
      logic [7:0] exp_d;
      rd_ok = r && (m_cnt != 0);
      wr_ok = w && ((m_cnt != 8) || r);
      exp_d = 8'h00;
      if (rd_ok) exp_d = sb.pop_front();
      if (wr_ok) sb.push_back(d);
      m_cnt = sb.size();
      cyc(w, r, d);
      check("mdl_rd_valid", 32'(rd_valid), 32'(rd_ok));
      if (rd_ok) check("mdl_data", 32'(data_out), 32'(exp_d));
      check("mdl_count", 32'(count), 32'(m_cnt));
   endtask

   logic [7:0] exp_drain [8] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA};

   initial begin
      reset   = 1'b1;
      write_e = 1'b0;
      read_e  = 1'b0;
      data_in = 8'h00;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b0;

      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_ae", 32'(almost_empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_af", 32'(almost_full), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_underflow", 32'(underflow), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);

      // Fill 0x01..0x08
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, 1'b0, 8'(i));
         check("fill_count", 32'(count), 32'(i));
         check("fill_full", 32'(full), 32'(i == 8));
         check("fill_af", 32'(almost_full), 32'(i >= 6));
         check("fill_ae", 32'(almost_empty), 32'(i <= 2));
         check("fill_empty", 32'(empty), 32'd0);
      end
      cyc(1'b1, 1'b0, 8'hFF);
      check("ovf_pulse", 32'(overflow), 32'd1);
      check("ovf_count", 32'(count), 32'd8);
      check("ovf_full", 32'(full), 32'd1);
      cyc(1'b0, 1'b0, 8'h00);
      check("ovf_clear", 32'(overflow), 32'd0);

      // Drain 0x01..0x08, dropped 0xFF must not appear
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b0, 1'b1, 8'h00);
         check("drain_data", 32'(data_out), 32'(i));
         check("drain_rd_valid", 32'(rd_valid), 32'd1);
         check("drain_count", 32'(count), 32'(8 - i));
      end
      cyc(1'b0, 1'b1, 8'h00);
      check("udf_pulse", 32'(underflow), 32'd1);
      check("udf_rd_valid", 32'(rd_valid), 32'd0);
      check("udf_empty", 32'(empty), 32'd1);
      check("udf_hold_data", 32'(data_out), 32'h08);
      cyc(1'b0, 1'b0, 8'h00);
      check("udf_clear", 32'(underflow), 32'd0);

      // Full FIFO with simultaneous read and write
      for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 8'(i));
      cyc(1'b1, 1'b1, 8'hAA);
      check("fullrw_data", 32'(data_out), 32'h01);
      check("fullrw_rd_valid", 32'(rd_valid), 32'd1);
      check("fullrw_count", 32'(count), 32'd8);
      check("fullrw_full", 32'(full), 32'd1);
      check("fullrw_overflow", 32'(overflow), 32'd0);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 1'b1, 8'h00);
         check("fullrw_drain", 32'(data_out), 32'(exp_drain[i]));
      end
      check("fullrw_empty", 32'(empty), 32'd1);

      // Empty FIFO with simultaneous read and write
      cyc(1'b1, 1'b1, 8'h55);
      check("emptyrw_underflow", 32'(underflow), 32'd1);
      check("emptyrw_rd_valid", 32'(rd_valid), 32'd0);
      check("emptyrw_count", 32'(count), 32'd1);
      check("emptyrw_empty", 32'(empty), 32'd0);
      cyc(1'b0, 1'b1, 8'h00);
      check("emptyrw_data", 32'(data_out), 32'h55);
      check("emptyrw_valid2", 32'(rd_valid), 32'd1);
      check("emptyrw_count2", 32'(count), 32'd0);

      // Interleaved traffic, 20 writes: write pointer wraps at least twice
      sb.delete();
      m_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         mcyc(1'b1, (k % 5) != 0, 8'(8'h10 + k));
      end
      for (int k = 0; k < 8; k++) begin
         if (m_cnt > 0) mcyc(1'b0, 1'b1, 8'h00);
      end
      check("wrap_empty", 32'(empty), 32'd1);

      // Reset mid-operation with a concurrent write
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i));
      check("pre_rst_count", 32'(count), 32'd5);
      reset = 1'b1;
      cyc(1'b1, 1'b0, 8'h99);
      reset = 1'b0;
      check("mid_rst_count", 32'(count), 32'd0);
      check("mid_rst_empty", 32'(empty), 32'd1);
      check("mid_rst_data", 32'(data_out), 32'd0);
      cyc(1'b0, 1'b0, 8'h00);
      check("mid_rst_count2", 32'(count), 32'd0);
      cyc(1'b1, 1'b0, 8'h33);
      check("post_rst_count", 32'(count), 32'd1);
      cyc(1'b0, 1'b1, 8'h00);
      check("post_rst_data", 32'(data_out), 32'h33);
      check("post_rst_valid", 32'(rd_valid), 32'd1);
      check("post_rst_empty", 32'(empty), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
